// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index width and pipeline controller FSM states.
package cpu_types_pkg;

   localparam int unsigned RegBits = 5;

   typedef logic [RegBits-1:0] regbits_t;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MEMWAIT = 2'd1,
      HALTED  = 2'd2
   } pipe_state_t;

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detector: a load in EX whose destination feeds the instruction in ID.
module hazard_unit
   import cpu_types_pkg::*;
(
   input  logic     ex_memread,
   input  regbits_t ex_rd,
   input  regbits_t id_rs,
   input  regbits_t id_rt,
   output logic     load_use
);

   // $zero is never a real dependency
   always_comb begin
      load_use = ex_memread && (ex_rd != '0) && ((ex_rd == id_rs) || (ex_rd == id_rt));
   end

endmodule

// File: rtl/pipeline_controller.sv
// Five-stage pipeline stall/flush/halt controller.
// Optional PIPE_CTRL_STATS_EN adds saturating stall_cnt/flush_cnt outputs.
module pipeline_controller
   import cpu_types_pkg::*;
(
   input  logic     CLK,
   input  logic     nRST,
   input  logic     ihit,
   input  logic     dhit,
   input  logic     mem_dreq,
   input  regbits_t id_rs,
   input  regbits_t id_rt,
   input  logic     ex_memread,
   input  regbits_t ex_rd,
   input  logic     ex_branch_taken,
   input  logic     wb_halt,
   output logic     pc_en,
   output logic     ifid_en,
   output logic     idex_en,
   output logic     exmem_en,
   output logic     memwb_en,
   output logic     ifid_flush,
   output logic     idex_flush,
   output logic     halt_out
`ifdef PIPE_CTRL_STATS_EN
  ,output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
`endif
);

   pipe_state_t state_q, state_d;
   logic        load_use;
   logic        mem_ok;
   logic        advance;

   hazard_unit u_hazard (
      .ex_memread (ex_memread),
      .ex_rd      (ex_rd),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .load_use   (load_use)
   );

   // Once waiting, only dhit releases the pipe even if mem_dreq has dropped
   always_comb begin
      mem_ok  = ((state_q != MEMWAIT) && !mem_dreq) || dhit;
      advance = ihit && mem_ok;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (state_q != HALTED && wb_halt && advance) begin
         state_d = HALTED;
      end else begin
         unique case (state_q)
            RUN:     if (mem_dreq && !dhit) state_d = MEMWAIT;
            MEMWAIT: if (dhit) state_d = RUN;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
         endcase
      end
   end

   always_comb begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      halt_out   = 1'b0;
      if (state_q == HALTED) begin
         halt_out = 1'b1;
      end else begin
         pc_en    = advance;
         ifid_en  = advance;
         idex_en  = advance;
         exmem_en = advance;
         memwb_en = advance;
         // Flushes only on an advancing cycle; a stalled branch waits in EX
         if (advance) begin
            if (ex_branch_taken) begin
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
            end else if (load_use) begin
               pc_en      = 1'b0;
               ifid_en    = 1'b0;
               idex_flush = 1'b1;
            end
         end
      end
   end

`ifdef PIPE_CTRL_STATS_EN
   logic stall_inc;

   always_comb begin
      stall_inc = (state_q != HALTED) && !advance;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_inc && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
         if (ifid_flush && flush_cnt != 32'hFFFF_FFFF) flush_cnt <= flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// Scoreboard bench for pipeline_controller; stats checks active under PIPE_CTRL_STATS_EN.
module tb_pipeline_controller;
   import cpu_types_pkg::*;

   logic     CLK;
   logic     nRST;
   logic     ihit, dhit, mem_dreq, ex_memread, ex_branch_taken, wb_halt;
   regbits_t id_rs, id_rt, ex_rd;
   logic     pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halt_out;
`ifdef PIPE_CTRL_STATS_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   pipeline_controller dut (
      .CLK             (CLK),
      .nRST            (nRST),
      .ihit            (ihit),
      .dhit            (dhit),
      .mem_dreq        (mem_dreq),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .ex_memread      (ex_memread),
      .ex_rd           (ex_rd),
      .ex_branch_taken (ex_branch_taken),
      .wb_halt         (wb_halt),
      .pc_en           (pc_en),
      .ifid_en         (ifid_en),
      .idex_en         (idex_en),
      .exmem_en        (exmem_en),
      .memwb_en        (memwb_en),
      .ifid_flush      (ifid_flush),
      .idex_flush      (idex_flush),
      .halt_out        (halt_out)
`ifdef PIPE_CTRL_STATS_EN
     ,.stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halt_out}
   localparam logic [7:0] RunAll = 8'hF8;
   localparam logic [7:0] Stall  = 8'h00;
   localparam logic [7:0] LdUse  = 8'h3A;
   localparam logic [7:0] Branch = 8'hFE;
   localparam logic [7:0] Halt   = 8'h01;

   typedef struct {
      string       name;
      logic [7:0]  outs;
      bit          chk;
      int unsigned st;
      int unsigned fl;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // Drive one cycle of inputs just after the rising edge and queue the expected response
   task automatic step(input string name, input logic rst, input logic ih, input logic dh,
                       input logic mreq, input logic mrd, input int rd, input int rs,
                       input int rt, input logic br, input logic hlt, input logic [7:0] outs,
                       input bit chk = 0, input int unsigned st = 0, input int unsigned fl = 0);
      exp_t e;
      @(posedge CLK);
      #1;
      nRST            = rst;
      ihit            = ih;
      dhit            = dh;
      mem_dreq        = mreq;
      ex_memread      = mrd;
      ex_rd           = regbits_t'(rd);
      id_rs           = regbits_t'(rs);
      id_rt           = regbits_t'(rt);
      ex_branch_taken = br;
      wb_halt         = hlt;
      e.name = name;
      e.outs = outs;
      e.chk  = chk;
      e.st   = st;
      e.fl   = fl;
      q.push_back(e);
   endtask

   always @(negedge CLK) begin
      exp_t       e;
      logic [7:0] act;
      if (q.size() > 0) begin
         e   = q.pop_front();
         act = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halt_out};
         checks++;
         if (act !== e.outs) begin
            errors++;
            $display("FAIL %s: outputs got %b want %b", e.name, act, e.outs);
         end
`ifdef PIPE_CTRL_STATS_EN
         if (e.chk) begin
            checks += 2;
            if (stall_cnt !== e.st) begin
               errors++;
               $display("FAIL %s: stall_cnt got %0d want %0d", e.name, stall_cnt, e.st);
            end
            if (flush_cnt !== e.fl) begin
               errors++;
               $display("FAIL %s: flush_cnt got %0d want %0d", e.name, flush_cnt, e.fl);
            end
         end
`endif
      end
   end

   initial begin
      int waited;
      nRST = 1'b0; ihit = 0; dhit = 0; mem_dreq = 0; ex_memread = 0;
      ex_rd = '0; id_rs = '0; id_rt = '0; ex_branch_taken = 0; wb_halt = 0;

      //    name             rst ih dh mq mr rd rs rt br hl outs
      step("reset_run",      0,  1, 0, 0, 0, 0, 0, 0, 0, 0, RunAll);
      step("reset_run2",     0,  1, 0, 0, 0, 0, 0, 0, 0, 0, RunAll);
      for (int i = 0; i < 3; i++)
         step("normal",      1,  1, 0, 0, 0, 0, 1, 2, 0, 0, RunAll);
      step("ihit_low",       1,  0, 0, 0, 0, 0, 0, 0, 0, 0, Stall);
      step("lu_rs",          1,  1, 0, 0, 1, 5, 5, 3, 0, 0, LdUse);
      step("lu_rt",          1,  1, 0, 0, 1, 7, 2, 7, 0, 0, LdUse);
      step("lu_rd0",         1,  1, 0, 0, 1, 0, 0, 0, 0, 0, RunAll);
      step("lu_nomatch",     1,  1, 0, 0, 1, 5, 3, 4, 0, 0, RunAll);
      step("lu_noload",      1,  1, 0, 0, 0, 5, 5, 5, 0, 0, RunAll);
      step("lu_ihit0",       1,  0, 0, 0, 1, 5, 5, 3, 0, 0, Stall);
      step("dreq_dhit",      1,  1, 1, 1, 0, 0, 0, 0, 0, 0, RunAll);
      step("memwait_1",      1,  1, 0, 1, 0, 0, 0, 0, 0, 0, Stall);
      step("memwait_2",      1,  1, 0, 1, 0, 0, 0, 0, 0, 0, Stall);
      step("memwait_3",      1,  1, 0, 1, 0, 0, 0, 0, 0, 0, Stall);
      step("memwait_dhit",   1,  1, 1, 0, 0, 0, 0, 0, 0, 0, RunAll);
      step("after_wait",     1,  1, 0, 0, 0, 0, 0, 0, 0, 0, RunAll);
      step("enter_wait",     1,  1, 0, 1, 0, 0, 0, 0, 0, 0, Stall);
      step("wait_dreq_drop", 1,  1, 0, 0, 0, 0, 0, 0, 0, 0, Stall);
      step("wait_release",   1,  1, 1, 0, 0, 0, 0, 0, 0, 0, RunAll);
      step("br_lu",          1,  1, 0, 0, 1, 5, 5, 0, 1, 0, Branch);
      step("br_plain",       1,  1, 0, 0, 0, 0, 0, 0, 1, 0, Branch);
      step("br_ihit0",       1,  0, 0, 0, 1, 5, 5, 0, 1, 0, Stall);
      step("br_dreq_wait",   1,  1, 0, 1, 0, 0, 0, 0, 1, 0, Stall);
      step("br_in_wait",     1,  1, 0, 0, 0, 0, 0, 0, 1, 0, Stall);
      step("br_wait_dhit",   1,  1, 1, 0, 0, 0, 0, 0, 1, 0, Branch);
      step("rst_enter_wait", 1,  1, 0, 1, 0, 0, 0, 0, 0, 0, Stall);
      step("rst_in_wait",    0,  1, 0, 0, 0, 0, 0, 0, 0, 0, RunAll);
      step("post_rst_run",   1,  1, 0, 0, 0, 0, 0, 0, 0, 0, RunAll);
      step("halt_ihit0",     1,  0, 0, 0, 0, 0, 0, 0, 0, 1, Stall);
      step("no_halt_yet",    1,  1, 0, 0, 0, 0, 0, 0, 0, 0, RunAll);
      step("halt_adv",       1,  1, 0, 0, 0, 0, 0, 0, 0, 1, RunAll);
      for (int i = 0; i < 10; i++)
         step("halted",      1,  1, i % 2, 0, 1, 5, 5, 5, i % 3 == 0, 0, Halt);
      step("halt_rst",       0,  1, 0, 0, 0, 0, 0, 0, 0, 0, RunAll);
      step("halt_cleared",   1,  1, 0, 0, 0, 0, 0, 0, 0, 0, RunAll);

      // Counter segment: 4 stall cycles then 2 flush cycles from a fresh reset
      step("st_reset",       0,  1, 0, 0, 0, 0, 0, 0, 0, 0, RunAll, 1, 0, 0);
      for (int i = 0; i < 4; i++)
         step("st_stall",    1,  0, 0, 0, 0, 0, 0, 0, 0, 0, Stall);
      step("st_flush1",      1,  1, 0, 0, 0, 0, 0, 0, 1, 0, Branch);
      step("st_flush2",      1,  1, 0, 0, 0, 0, 0, 0, 1, 0, Branch);
      step("st_count",       1,  1, 0, 0, 0, 0, 0, 0, 0, 0, RunAll, 1, 4, 2);
      step("st_clear",       0,  1, 0, 0, 0, 0, 0, 0, 0, 0, RunAll, 1, 0, 0);

      waited = 0;
      while (q.size() > 0 && waited < 20) begin
         @(posedge CLK);
         waited++;
      end
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 SHALL have port CLK  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port nRST  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port ihit  in  1  instruction fetch completes this cycle.
REQ-004 SHALL have port dhit  in  1  data access completes this cycle.
REQ-005 SHALL have port mem_dreq  in  1  instruction in MEM has dREN or dWEN set.
REQ-006 SHALL have ports id_rs, id_rt  in  5 (regbits_t)  source registers of instruction in ID.
REQ-007 SHALL have ports ex_memread  in  1 and ex_rd  in  5 (regbits_t)  load destination in EX.
REQ-008 SHALL have port ex_branch_taken  in  1  branch/jump resolved taken in EX.
REQ-009 SHALL have port wb_halt  in  1  halt instruction in WB.
REQ-010 SHALL have ports pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register write enables.
REQ-011 SHALL have ports ifid_flush, idex_flush  out  1 each  synchronous bubble insert (contents zeroed when flush and enable both high).
REQ-012 SHALL have port halt_out  out  1  processor halted, sticky.

Function
REQ-013 SHALL implement FSM states RUN, MEMWAIT, HALTED (type pipe_state_t).
REQ-014 SHALL define mem_ok = (state!=MEMWAIT && !mem_dreq) || dhit; advance = ihit && mem_ok.
REQ-015 SHALL transition RUN->MEMWAIT when mem_dreq && !dhit; MEMWAIT->RUN on dhit, even if mem_dreq has since dropped.
REQ-016 SHALL transition any state->HALTED when wb_halt && advance; HALTED exits only by reset.
REQ-017 SHALL, in RUN/MEMWAIT, drive all five enables = advance, flushes = 0, by default.
REQ-018 SHALL detect load-use = ex_memread && ex_rd!=0 && (ex_rd==id_rs || ex_rd==id_rt); when set and advance: pc_en=0, ifid_en=0, idex_flush=1, others = advance.
REQ-019 SHALL, when ex_branch_taken && advance: pc_en=1, ifid_flush=1, idex_flush=1; branch overrides load-use.
REQ-020 SHALL assert no flush when advance=0 (stalled pipe holds; branch remains in EX and is handled at next advance).
REQ-021 SHALL, in HALTED, drive all enables and flushes 0 and halt_out=1.
REQ-022 SHALL produce all outputs combinationally from state and inputs (zero-cycle latency); only state and counters are registered.

Reset
REQ-023 SHALL, while nRST=0, force state RUN, halt_out 0, all counters 0; enables/flushes follow REQ-017 from RUN.
REQ-024 SHALL, on reset mid-MEMWAIT, discard the pending access wait and resume RUN rules on the first cycle after release.

Configuration
REQ-025 SHALL support macro PIPE_CTRL_STATS_EN: when defined, add outputs stall_cnt 32 (cycles with advance=0 outside HALTED) and flush_cnt 32 (cycles with ifid_flush=1), saturating at 32'hFFFFFFFF, frozen in HALTED.
REQ-026 SHALL, without PIPE_CTRL_STATS_EN, omit both ports and counter logic entirely.

Structure
REQ-027 SHALL place pipe_state_t enum in cpu_types_pkg; regbits_t reused from it.
REQ-028 SHALL isolate load-use comparison in combinational sub-module hazard_unit.

Verification
REQ-029 SHALL cover: ihit=1, mem_dreq=0, no hazards -> all enables 1, flushes 0 every cycle.
REQ-030 SHALL cover: ex_memread=1, ex_rd=5, id_rs=5, ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1; ex_rd=0 same case -> no stall.
REQ-031 SHALL cover: mem_dreq=1, dhit=0 three cycles then mem_dreq=0, dhit=1 -> enables 0 for three cycles, state MEMWAIT, enables 1 on dhit cycle.
REQ-032 SHALL cover: ex_branch_taken=1 with load-use true, ihit=1 -> pc_en=1, ifid_flush=1, idex_flush=1; with ihit=0 -> no flush.
REQ-033 SHALL cover: wb_halt=1, ihit=1 -> next cycle halt_out=1, all enables 0 for 10 cycles; nRST pulse -> halt_out=0.
REQ-034 SHALL cover (PIPE_CTRL_STATS_EN): 4 stall cycles, 2 flush cycles -> stall_cnt=4, flush_cnt=2; reset -> both 0.
